papertape_punch: RTL and testbench
==================================

PAPERTAPE_PUNCH -- requirements
Module: papertape_punch

Interface
REQ-001 Parameter DEVICE_ADDR, default 11'h002; the device number this punch answers to.
REQ-002 Parameter PUNCH_CYCLES, default 8; clocks per punched frame, legal range >=2.
REQ-003 Parameter FIFO_DEPTH, default 4; byte buffer depth, power of two.
REQ-004 Parameter TAPE_LEN, default 1024; tape image length in frames, power of two.
REQ-005 Ports: clock input 1 (posedge); reset input 1 (asynchronous, active-high).
REQ-006 Ports: iop_func input 3, bus function code [0:2]; iop_device input 11, addressed device [0:10].
REQ-007 Ports: wr_data input 8, byte from IOP [0:7]; wr_valid input 1, byte offered this cycle.
REQ-008 Ports: wr_ready output 1, byte accepted when wr_valid & wr_ready at posedge.
REQ-009 Ports: iop_cc output 2, status condition code [0:1]; busy output 1.
REQ-010 Ports: punch_strobe output 1, one-cycle pulse per frame punched; punch_data output 8, frame value.
REQ-011 Ports: tape_count output 17, frames punched since reset [15:31].

Function
REQ-012 Function codes: 0 none, 1 SIO (start), 2 TIO (test), 3 HIO (halt); other codes ignored; decoded only when iop_device == DEVICE_ADDR.
REQ-013 iop_cc combinational when addressed: 00 idle/ready, 01 busy (FIFO non-empty or punching), 10 tape full, 11 not started; 00 when not addressed.
REQ-014 States: STOPPED, IDLE, LOAD, PUNCH; after reset STOPPED.
REQ-015 STOPPED -> IDLE on SIO; any state -> STOPPED on HIO in the same cycle, FIFO flushed, in-flight frame abandoned, no strobe.
REQ-016 wr_ready = 1 only in IDLE/LOAD/PUNCH with FIFO not full and tape not full.
REQ-017 Push and pop in the same cycle when full: push refused (wr_ready already 0); when empty: pop has nothing, push stored.
REQ-018 IDLE -> LOAD when FIFO non-empty; LOAD pops head into frame register, one cycle, -> PUNCH.
REQ-019 PUNCH counts PUNCH_CYCLES clocks; on the last count: punch_strobe=1, punch_data=frame, tape[tape_count] written, tape_count+1; then LOAD if FIFO non-empty else IDLE.
REQ-020 Latency: byte accepted into empty FIFO in IDLE -> strobe exactly PUNCH_CYCLES+2 clocks after acceptance edge.
REQ-021 Back-to-back throughput: one frame per PUNCH_CYCLES+1 clocks.
REQ-022 Tape full when tape_count == TAPE_LEN; further bytes refused, remaining FIFO bytes discarded, state -> IDLE; tape_count saturates, never wraps.
REQ-023 busy = state in {LOAD, PUNCH} or FIFO non-empty.
REQ-024 FIFO pointers modulo FIFO_DEPTH with extra wrap bit for full/empty distinction.
REQ-025 SIO while already started is a no-op; TIO never changes state.

Reset
REQ-026 On reset: state STOPPED, FIFO empty, tape_count 0, punch_strobe 0, punch_data 0, wr_ready 0, busy 0, cycle counter 0.
REQ-027 Reset mid-PUNCH abandons the frame: no strobe, no tape write; tape image contents not cleared.

Structure
REQ-028 Function-code constants (NONE, SIO, TIO, HIO) and cc encodings live in the shared IOP definitions include, common with the IOP and paper tape reader.
REQ-029 One sub-module: byte_fifo (parameterised depth/width, push/pop/full/empty); tape image is a reg array named tape, loadable/dumpable by $readmemh/$writememh from the bench.

Verification
REQ-030 Reset, TIO on DEVICE_ADDR -> iop_cc=11, wr_ready=0; SIO then TIO -> iop_cc=00, wr_ready=1.
REQ-031 SIO, push 8'hA5 in IDLE -> punch_strobe exactly 10 clocks later (PUNCH_CYCLES=8), punch_data=A5, tape[0]=A5, tape_count=1.
REQ-032 Push 5 bytes 01..05 continuously -> wr_ready drops after 4 accepted plus 1 popped, all 5 punched in order at 9-clock spacing.
REQ-033 HIO mid-PUNCH with 2 bytes queued -> no further strobes, busy=0 next cycle, tape_count unchanged.
REQ-034 TAPE_LEN=4, push 6 bytes -> tape_count stops at 4, iop_cc=10, wr_ready=0, no 5th strobe.
REQ-035 Assert reset during PUNCH -> all outputs at reset values, tape_count=0, no strobe for the in-flight frame.

Source files
------------

// File: rtl/papertape_punch_pkg.sv
// ---------------------------------------------------------------------------
// papertape_punch_pkg
// Shared IOP bus definitions (function codes, condition codes) used by the
// IOP, the paper tape reader and the paper tape punch, plus the punch FSM
// state constants and small decode helpers.
//
// Bit numbering note: the IOP documents fields MSB-first as [0:n]. In RTL the
// fields are declared [n:0], so IOP bit 0 is the MSB of each vector.
// ---------------------------------------------------------------------------
package papertape_punch_pkg;

    // IOP bus function codes
    localparam logic [2:0] FUNC_NONE = 3'd0;
    localparam logic [2:0] FUNC_SIO  = 3'd1;   // start I/O
    localparam logic [2:0] FUNC_TIO  = 3'd2;   // test I/O (status only)
    localparam logic [2:0] FUNC_HIO  = 3'd3;   // halt I/O

    // IOP condition codes returned on iop_cc
    localparam logic [1:0] CC_READY       = 2'b00;
    localparam logic [1:0] CC_BUSY        = 2'b01;
    localparam logic [1:0] CC_TAPE_FULL   = 2'b10;
    localparam logic [1:0] CC_NOT_STARTED = 2'b11;

    // Punch controller states
    localparam logic [1:0] ST_STOPPED = 2'd0;
    localparam logic [1:0] ST_IDLE    = 2'd1;
    localparam logic [1:0] ST_LOAD    = 2'd2;
    localparam logic [1:0] ST_PUNCH   = 2'd3;

    // Commands that actually change controller state. TIO only reads status,
    // so it needs no decode of its own.
    typedef struct packed {
        logic sio;
        logic hio;
    } iop_cmd_t;

    function automatic iop_cmd_t decode_iop(input logic addressed, input logic [2:0] func);
        iop_cmd_t cmd;
        cmd.sio = addressed && (func == FUNC_SIO);
        cmd.hio = addressed && (func == FUNC_HIO);
        return cmd;
    endfunction

    // Status priority: a stopped device reports "not started" before anything
    // else; a full tape outranks busy (the buffer is discarded when it fills).
    function automatic logic [1:0] status_cc(input logic started,
                                             input logic tape_full,
                                             input logic busy);
        logic [1:0] cc;
        if (!started) begin
            cc = CC_NOT_STARTED;
        end else if (tape_full) begin
            cc = CC_TAPE_FULL;
        end else if (busy) begin
            cc = CC_BUSY;
        end else begin
            cc = CC_READY;
        end
        return cc;
    endfunction

endpackage

// File: rtl/papertape_punch_byte_fifo.sv
// ---------------------------------------------------------------------------
// papertape_punch_byte_fifo
// Small synchronous FIFO buffering bytes between the IOP write port and the
// punch mechanism. Read-ahead: the head entry is always visible on `head`.
//
// Ports
//   clock, reset   : clock and asynchronous active-high reset
//   flush          : empties the FIFO; wins over a same-cycle push/pop
//   push, push_data: write request (ignored when full)
//   pop            : remove head entry (ignored when empty)
//   head           : current head entry (undefined while empty)
//   full, empty    : occupancy flags
//
// DEPTH must be a power of two, >= 2. Pointers carry one extra wrap bit so
// that full and empty are distinguishable when the indices match.
// ---------------------------------------------------------------------------
module papertape_punch_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr_reg;
    logic [PTR_W:0]   rd_ptr_reg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] slot_we;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                   (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);

    // A push into a full FIFO is dropped here as a second line of defence;
    // the producer is expected to honour `full` already.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    assign head = mem[rd_ptr_reg[PTR_W-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + (PTR_W+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + (PTR_W+1)'(1);
            end
        end
    end

    // Per-slot write enables.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_we
            assign slot_we[gi] = do_push && (wr_ptr_reg[PTR_W-1:0] == PTR_W'(gi));
        end
    endgenerate

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_we[i]) begin
                mem[i] <= push_data;
            end
        end
    end

endmodule

// File: rtl/papertape_punch.sv
// ---------------------------------------------------------------------------
// papertape_punch
// IOP-attached paper tape punch. Bytes written by the IOP are buffered in a
// small FIFO, loaded one at a time into a frame register and "punched" after
// PUNCH_CYCLES clocks, at which point the frame is recorded in the tape image
// and announced with a one-cycle strobe.
//
// Ports
//   clock, reset     : clock and asynchronous active-high reset
//   iop_func[2:0]    : IOP function code (NONE/SIO/TIO/HIO)
//   iop_device[10:0] : addressed device number
//   wr_data[7:0]     : byte from the IOP
//   wr_valid         : byte offered this cycle
//   wr_ready         : byte accepted when wr_valid & wr_ready at posedge
//   iop_cc[1:0]      : status condition code (00 when not addressed)
//   busy             : loading/punching or bytes waiting in the buffer
//   punch_strobe     : one-cycle pulse per frame punched
//   punch_data[7:0]  : value of the most recently punched frame
//   tape_count[16:0] : frames punched since reset; saturates at TAPE_LEN
//
// The tape image `tape` is a plain array so a bench can inspect it by
// hierarchical reference; it is deliberately not cleared by reset.
// ---------------------------------------------------------------------------
module papertape_punch
    import papertape_punch_pkg::*;
#(
    parameter logic [10:0] DEVICE_ADDR  = 11'h002,
    parameter int          PUNCH_CYCLES = 8,      // >= 2
    parameter int          FIFO_DEPTH   = 4,      // power of two, >= 2
    parameter int          TAPE_LEN     = 1024    // power of two, <= 65536
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  iop_func,
    input  logic [10:0] iop_device,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [1:0]  iop_cc,
    output logic        busy,
    output logic        punch_strobe,
    output logic [7:0]  punch_data,
    output logic [16:0] tape_count
);

    localparam int              CNT_W      = $clog2(PUNCH_CYCLES);
    localparam int              TAPE_AW    = (TAPE_LEN > 1) ? $clog2(TAPE_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PUNCH_CYCLES - 1);
    localparam logic [16:0]     TAPE_FULL_COUNT = 17'(TAPE_LEN);

    // Tape image
    logic [7:0] tape [TAPE_LEN];

    // Controller state
    logic [1:0]       state_reg,  state_next;
    logic [CNT_W-1:0] cycle_reg,  cycle_next;
    logic [7:0]       frame_reg,  frame_next;
    logic             strobe_next;
    logic [7:0]       data_next;
    logic [16:0]      count_next;
    logic             tape_we;

    // Bus decode and status
    logic     addressed;
    iop_cmd_t cmd;
    logic     started;
    logic     tape_full;

    // FIFO interface
    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_flush;
    logic [7:0] fifo_head;
    logic       fifo_full;
    logic       fifo_empty;

    assign addressed = (iop_device == DEVICE_ADDR);
    assign cmd       = decode_iop(addressed, iop_func);
    assign started   = (state_reg != ST_STOPPED);
    assign tape_full = (tape_count == TAPE_FULL_COUNT);

    assign wr_ready  = started && !fifo_full && !tape_full;
    assign busy      = (state_reg == ST_LOAD) || (state_reg == ST_PUNCH) || !fifo_empty;
    assign iop_cc    = addressed ? status_cc(started, tape_full, busy) : CC_READY;
    assign fifo_push = wr_valid && wr_ready;

    papertape_punch_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) byte_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_next  = state_reg;
        cycle_next  = cycle_reg;
        frame_next  = frame_reg;
        strobe_next = 1'b0;
        data_next   = punch_data;
        count_next  = tape_count;
        tape_we     = 1'b0;
        fifo_pop    = 1'b0;
        fifo_flush  = 1'b0;

        if (cmd.hio) begin
            // Halt overrides everything, including a frame finishing this
            // very cycle: it is abandoned without strobe or tape write.
            state_next = ST_STOPPED;
            cycle_next = '0;
            fifo_flush = 1'b1;
        end else begin
            case (state_reg)
                ST_STOPPED: begin
                    if (cmd.sio) begin
                        state_next = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state_next = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    fifo_pop   = 1'b1;
                    frame_next = fifo_head;
                    cycle_next = '0;
                    state_next = ST_PUNCH;
                end
                ST_PUNCH: begin
                    if (cycle_reg == CNT_LAST) begin
                        strobe_next = 1'b1;
                        data_next   = frame_reg;
                        tape_we     = !tape_full;
                        count_next  = tape_full ? tape_count : tape_count + 17'd1;
                        cycle_next  = '0;
                        if (count_next == TAPE_FULL_COUNT) begin
                            // Tape just ran out: drop whatever is still buffered.
                            fifo_flush = 1'b1;
                            state_next = ST_IDLE;
                        end else if (!fifo_empty) begin
                            state_next = ST_LOAD;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        cycle_next = cycle_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_next = ST_STOPPED;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_STOPPED;
            cycle_reg    <= '0;
            frame_reg    <= '0;
            punch_strobe <= 1'b0;
            punch_data   <= '0;
            tape_count   <= '0;
        end else begin
            state_reg    <= state_next;
            cycle_reg    <= cycle_next;
            frame_reg    <= frame_next;
            punch_strobe <= strobe_next;
            punch_data   <= data_next;
            tape_count   <= count_next;
        end
    end

    // Tape image write port: no reset, contents survive reset.
    always_ff @(posedge clock) begin
        if (tape_we) begin
            tape[tape_count[TAPE_AW-1:0]] <= frame_reg;
        end
    end

endmodule

// File: tb/tb_papertape_punch.sv
// ---------------------------------------------------------------------------
// tb_papertape_punch
// Two punches share one stimulus: `dut` (default parameters) is compared on
// every cycle against a queue/timer model; `dut_small` (TAPE_LEN=4) is used
// for the tape-full scenario with literal expectations.
// ---------------------------------------------------------------------------
module tb_papertape_punch;

    localparam logic [10:0] ADDR = 11'h002;
    localparam int PC    = 8;
    localparam int DEPTH = 4;
    localparam int LEN   = 1024;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  iop_func = 3'd0;
    logic [10:0] iop_device = 11'd0;
    logic [7:0]  wr_data = 8'd0;
    logic        wr_valid = 1'b0;

    logic        wr_ready, busy, punch_strobe;
    logic [1:0]  iop_cc;
    logic [7:0]  punch_data;
    logic [16:0] tape_count;

    logic        small_wr_ready, small_busy, small_strobe;
    logic [1:0]  small_cc;
    logic [7:0]  small_data;
    logic [16:0] small_count;

    always #5 clock = ~clock;

    papertape_punch #(.DEVICE_ADDR(ADDR), .PUNCH_CYCLES(PC), .FIFO_DEPTH(DEPTH), .TAPE_LEN(LEN)) dut (
        .clock(clock), .reset(reset), .iop_func(iop_func), .iop_device(iop_device),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .iop_cc(iop_cc),
        .busy(busy), .punch_strobe(punch_strobe), .punch_data(punch_data), .tape_count(tape_count)
    );

    papertape_punch #(.DEVICE_ADDR(ADDR), .PUNCH_CYCLES(PC), .FIFO_DEPTH(DEPTH), .TAPE_LEN(4)) dut_small (
        .clock(clock), .reset(reset), .iop_func(iop_func), .iop_device(iop_device),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(small_wr_ready), .iop_cc(small_cc),
        .busy(small_busy), .punch_strobe(small_strobe), .punch_data(small_data), .tape_count(small_count)
    );

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- behavioural model ----------------
    // Bytes wait in m_q; a frame is taken from the queue one edge after the
    // punch becomes free with bytes waiting (or immediately on the edge after
    // a frame completes if bytes were already waiting), and completes PC
    // edges after it was taken.
    logic [7:0] m_q[$];
    bit         m_started = 0;
    int         m_timer = 0;      // edges left until current frame completes
    bit         m_pop_next = 0;   // a frame will be taken on the next edge
    logic [7:0] m_frame = 8'h00;
    bit         m_strobe = 0;
    logic [7:0] m_data = 8'h00;
    int         m_count = 0;
    logic [7:0] m_tape [LEN];
    bit         m_written [LEN];

    function automatic bit m_wr_ready();
        return m_started && (m_q.size() < DEPTH) && (m_count < LEN);
    endfunction

    function automatic bit m_busy();
        return m_pop_next || (m_timer > 0) || (m_q.size() > 0);
    endfunction

    always @(posedge clock or posedge reset) begin
        bit addr, hio, sio, push;
        int qn;
        if (reset) begin
            m_started = 0; m_q.delete(); m_timer = 0; m_pop_next = 0;
            m_strobe = 0; m_data = 8'h00; m_count = 0;
        end else begin
            addr = (iop_device == ADDR);
            hio  = addr && (iop_func == 3'd3);
            sio  = addr && (iop_func == 3'd1);
            push = wr_valid && m_wr_ready();
            qn   = m_q.size();
            m_strobe = 0;
            if (hio) begin
                m_started = 0; m_q.delete(); m_timer = 0; m_pop_next = 0;
            end else begin
                if (m_timer == 1) begin
                    m_strobe = 1;
                    m_data = m_frame;
                    m_tape[m_count % LEN] = m_frame;
                    m_written[m_count % LEN] = 1;
                    m_count++;
                    m_timer = 0;
                    if (m_count == LEN) begin
                        m_q.delete(); m_pop_next = 0; push = 0;
                    end else begin
                        m_pop_next = (qn > 0);
                    end
                end else if (m_timer > 1) begin
                    m_timer--;
                end else if (m_pop_next) begin
                    m_frame = m_q.pop_front();
                    m_timer = PC;
                    m_pop_next = 0;
                end else if (m_started && qn > 0) begin
                    m_pop_next = 1;
                end
                if (sio) m_started = 1;
                if (push) m_q.push_back(wr_data);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        logic [1:0] ecc;
        if (check_en) begin
            if (iop_device != ADDR)        ecc = 2'b00;
            else if (!m_started)           ecc = 2'b11;
            else if (m_count == LEN)       ecc = 2'b10;
            else if (m_busy())             ecc = 2'b01;
            else                           ecc = 2'b00;
            check("wr_ready",     32'(wr_ready),     32'(m_wr_ready()));
            check("busy",         32'(busy),         32'(m_busy()));
            check("iop_cc",       32'(iop_cc),       32'(ecc));
            check("punch_strobe", 32'(punch_strobe), 32'(m_strobe));
            check("punch_data",   32'(punch_data),   32'(m_data));
            check("tape_count",   32'(tape_count),   32'(m_count));
        end
    end

    // Strobe log for the directed scenarios.
    int         s_cyc[$];
    logic [7:0] s_dat[$];
    int         small_strobes = 0;
    always @(negedge clock) begin
        if (punch_strobe) begin
            s_cyc.push_back(cyc);
            s_dat.push_back(punch_data);
        end
        if (small_strobe) small_strobes++;
    end

    task automatic drive(input logic [10:0] dev, input logic [2:0] fn, input logic v, input logic [7:0] d);
        @(posedge clock);
        #1;
        iop_device = dev; iop_func = fn; wr_valid = v; wr_data = d;
        #1;
    endtask

    task automatic idle();
        drive(ADDR, 3'd0, 1'b0, 8'h00);
    endtask

    task automatic wait_strobes(input int n, input int limit);
        for (int k = 0; k < limit && s_cyc.size() < n; k++) @(negedge clock);
    endtask

    task automatic clear_log();
        s_cyc.delete();
        s_dat.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc, attempts, first_acc, acc_cyc, p;
        logic [10:0] dev;
        logic [2:0]  fn;
        int r;

        // ---- reset and start/test handshake ----
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check_en = 1'b1;
        drive(ADDR, 3'd2, 1'b0, 8'h00);
        check("t1_cc_not_started", 32'(iop_cc), 32'h3);
        check("t1_ready_stopped", 32'(wr_ready), 32'h0);
        check("t1_busy_reset", 32'(busy), 32'h0);
        check("t1_count_reset", 32'(tape_count), 32'h0);
        check("t1_data_reset", 32'(punch_data), 32'h0);
        drive(ADDR, 3'd1, 1'b0, 8'h00);
        drive(ADDR, 3'd2, 1'b0, 8'h00);
        check("t1_cc_ready", 32'(iop_cc), 32'h0);
        check("t1_ready_started", 32'(wr_ready), 32'h1);

        // ---- single byte latency ----
        clear_log();
        drive(ADDR, 3'd0, 1'b1, 8'hA5);
        check("t2_accept", 32'(wr_ready), 32'h1);
        acc_cyc = cyc + 1;
        idle();
        wait_strobes(1, 40);
        check("t2_strobe_count", 32'(s_cyc.size()), 32'h1);
        if (s_cyc.size() >= 1) begin
            check("t2_latency", 32'(s_cyc[0] - acc_cyc), 32'd10);
            check("t2_data", 32'(s_dat[0]), 32'hA5);
        end
        check("t2_tape_count", 32'(tape_count), 32'h1);
        check("t2_tape0", 32'(dut.tape[0]), 32'hA5);

        // ---- back-to-back stream 01..05 ----
        clear_log();
        n_acc = 0; attempts = 0; first_acc = 0;
        while (n_acc < 5 && attempts < 20) begin
            drive(ADDR, 3'd0, 1'b1, 8'(n_acc + 1));
            attempts++;
            if (wr_ready) begin
                if (n_acc == 0) first_acc = cyc + 1;
                n_acc++;
            end
        end
        check("t3_accepted", 32'(n_acc), 32'd5);
        check("t3_no_stall", 32'(attempts), 32'd5);
        idle();
        check("t3_ready_drop", 32'(wr_ready), 32'h0);
        wait_strobes(5, 80);
        check("t3_strobe_count", 32'(s_cyc.size()), 32'd5);
        if (s_cyc.size() >= 1) check("t3_first_latency", 32'(s_cyc[0] - first_acc), 32'd10);
        for (int k = 0; k < s_cyc.size(); k++) begin
            check("t3_data_order", 32'(s_dat[k]), 32'(k + 1));
            if (k > 0) check("t3_spacing", 32'(s_cyc[k] - s_cyc[k-1]), 32'd9);
            check("t3_tape", 32'(dut.tape[k + 1]), 32'(k + 1));
        end
        check("t3_tape_count", 32'(tape_count), 32'd6);

        // ---- halt mid-punch with two bytes queued ----
        clear_log();
        drive(ADDR, 3'd0, 1'b1, 8'h11);
        drive(ADDR, 3'd0, 1'b1, 8'h22);
        drive(ADDR, 3'd0, 1'b1, 8'h33);
        repeat (3) idle();
        check("t4_busy_before_halt", 32'(busy), 32'h1);
        drive(ADDR, 3'd3, 1'b0, 8'h00);
        drive(ADDR, 3'd2, 1'b0, 8'h00);
        check("t4_busy_after_halt", 32'(busy), 32'h0);
        check("t4_ready_after_halt", 32'(wr_ready), 32'h0);
        check("t4_cc_after_halt", 32'(iop_cc), 32'h3);
        repeat (30) idle();
        check("t4_no_strobe", 32'(s_cyc.size()), 32'h0);
        check("t4_count_kept", 32'(tape_count), 32'd6);

        // ---- reset while punching ----
        clear_log();
        drive(ADDR, 3'd1, 1'b0, 8'h00);
        drive(ADDR, 3'd0, 1'b1, 8'h3C);
        repeat (5) idle();
        @(posedge clock);
        #1 reset = 1'b1;
        #1;
        check("t6_strobe", 32'(punch_strobe), 32'h0);
        check("t6_count", 32'(tape_count), 32'h0);
        check("t6_data", 32'(punch_data), 32'h0);
        check("t6_ready", 32'(wr_ready), 32'h0);
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_cc", 32'(iop_cc), 32'h3);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        repeat (20) idle();
        check("t6_no_strobe", 32'(s_cyc.size()), 32'h0);
        check("t6_count_after", 32'(tape_count), 32'h0);
        check("t6_tape_kept", 32'(dut.tape[0]), 32'hA5);

        // ---- tape full on the 4-frame punch ----
        small_strobes = 0;
        drive(ADDR, 3'd1, 1'b0, 8'h00);
        n_acc = 0; attempts = 0;
        while (n_acc < 6 && attempts < 60) begin
            drive(ADDR, 3'd0, 1'b1, 8'(8'hC0 + n_acc));
            attempts++;
            if (small_wr_ready) n_acc++;
        end
        check("t5_accepted", 32'(n_acc), 32'd6);
        repeat (100) idle();
        check("t5_strobes", 32'(small_strobes), 32'd4);
        check("t5_count", 32'(small_count), 32'd4);
        check("t5_cc_full", 32'(small_cc), 32'h2);
        check("t5_ready", 32'(small_wr_ready), 32'h0);
        check("t5_busy", 32'(small_busy), 32'h0);
        check("t5_last_data", 32'(small_data), 32'hC3);
        for (int k = 0; k < 4; k++) check("t5_tape", 32'(dut_small.tape[k]), 32'(8'hC0 + k));

        // ---- randomized episodes against the model ----
        for (int ep = 0; ep < 6; ep++) begin
            @(posedge clock);
            #1 reset = 1'b1;
            @(posedge clock);
            #1 reset = 1'b0;
            drive(ADDR, 3'd1, 1'b0, 8'h00);
            p = $urandom_range(1, 4);
            for (int c = 0; c < 400; c++) begin
                if ($urandom_range(0, 299) == 0) begin
                    @(posedge clock);
                    #1 reset = 1'b1;
                    @(posedge clock);
                    #1 reset = 1'b0;
                end
                dev = ($urandom_range(0, 4) == 0) ? 11'($urandom) : ADDR;
                r = $urandom_range(0, 199);
                if (r < 3)       fn = 3'd3;
                else if (r < 15) fn = 3'd1;
                else if (r < 30) fn = 3'd2;
                else if (r < 36) fn = 3'($urandom_range(4, 7));
                else             fn = 3'd0;
                drive(dev, fn, 1'($urandom_range(0, 3) < p), 8'($urandom));
            end
        end
        idle();
        for (int i = 0; i < LEN; i++) begin
            if (m_written[i]) check("tape_image", 32'(dut.tape[i]), 32'(m_tape[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
